// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: field widths, the reservation-station entry
// record and the CDB wakeup match helper.
package ooo_pkg;

    localparam int TAG_W = 4;
    localparam int VAL_W = 16;
    localparam int OPC_W = 4;
    localparam int IMM_W = 8;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [VAL_W-1:0] val_t;
    typedef logic [OPC_W-1:0] opc_t;
    typedef logic [IMM_W-1:0] imm_t;

    typedef struct packed {
        logic busy;
        tag_t rob_idx;
        opc_t opcode;
        imm_t imm;
        logic a_valid;
        val_t a_value;
        tag_t a_owner;
        logic b_valid;
        val_t b_value;
        tag_t b_owner;
    } rs_entry_t;

    // A still-pending operand picks up the broadcast when its producer tag matches.
    function automatic logic tag_hit(input logic op_valid, input tag_t owner,
                                     input logic cdb_v, input tag_t cdb_t);
        return !op_valid && cdb_v && (owner == cdb_t);
    endfunction

endpackage

// File: rtl/rs_pick_oldest.sv
// Fixed-priority picker: grants the lowest-indexed requester, which in the
// collapsing queue is the oldest ready entry.
module rs_pick_oldest #(
    parameter int DEPTH = 4
) (
    input  logic [DEPTH-1:0] req,
    output logic [DEPTH-1:0] grant,
    output logic             valid
);

    // Scan from slot 0 upward and stop at the first request.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (req[i] && !valid) begin
                grant[i] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fxu_reservation_station.sv
// FXU reservation station: age-ordered collapsing queue of DEPTH entries with
// CDB wakeup and oldest-ready issue.
// Optional feature macro: RS_WAKEUP_FASTPATH_EN -- when defined, an entry woken
// by the current-cycle CDB may issue in that same cycle with the operand taken
// straight from cdb_value. Otherwise readiness and issue operands come only
// from registered entry state.
module fxu_reservation_station
    import ooo_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_rob_idx,
    input  logic [OPC_W-1:0] in_opcode,
    input  logic [IMM_W-1:0] in_imm,
    input  logic             in_a_valid,
    input  logic [VAL_W-1:0] in_a_value,
    input  logic [TAG_W-1:0] in_a_owner,
    input  logic             in_b_valid,
    input  logic [VAL_W-1:0] in_b_value,
    input  logic [TAG_W-1:0] in_b_owner,
    input  logic             flush,
    output logic             full,
    output logic [3:0]       count,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [VAL_W-1:0] cdb_value,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [TAG_W-1:0] issue_rob_idx,
    output logic [OPC_W-1:0] issue_opcode,
    output logic [IMM_W-1:0] issue_imm,
    output logic [VAL_W-1:0] issue_a,
    output logic [VAL_W-1:0] issue_b
);

    rs_entry_t        entries_q [DEPTH];
    rs_entry_t        entries_d [DEPTH];
    // One extra always-empty slot past the top so the collapse can read i+1 uniformly.
    rs_entry_t        woke_ext  [DEPTH+1];
    rs_entry_t        issue_src [DEPTH];
    rs_entry_t        alloc;
    logic [3:0]       count_q;
    logic [3:0]       count_d;
    logic [3:0]       count_after;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic             pick_valid;
    logic             fire;
    logic             accept;
    logic             removed;

    assign full        = (count_q == 4'(DEPTH));
    assign count       = count_q;
    assign issue_valid = pick_valid;
    assign fire        = pick_valid & issue_ready;
    assign accept      = in_valid & ~full;

    // Apply this cycle's CDB broadcast to every busy entry's pending operands.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woke_ext[i] = entries_q[i];
            if (entries_q[i].busy &&
                tag_hit(entries_q[i].a_valid, entries_q[i].a_owner, cdb_valid, cdb_tag)) begin
                woke_ext[i].a_valid = 1'b1;
                woke_ext[i].a_value = cdb_value;
            end
            if (entries_q[i].busy &&
                tag_hit(entries_q[i].b_valid, entries_q[i].b_owner, cdb_valid, cdb_tag)) begin
                woke_ext[i].b_valid = 1'b1;
                woke_ext[i].b_value = cdb_value;
            end
        end
        woke_ext[DEPTH] = '0;
    end

    // Choose which view of the entries drives readiness and issue data.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_WAKEUP_FASTPATH_EN
            issue_src[i] = woke_ext[i];
`else
            issue_src[i] = entries_q[i];
`endif
            ready[i] = issue_src[i].busy & issue_src[i].a_valid & issue_src[i].b_valid;
        end
    end

    rs_pick_oldest #(
        .DEPTH (DEPTH)
    ) u_pick (
        .req   (ready),
        .grant (grant),
        .valid (pick_valid)
    );

    // One-hot AND-OR mux; all data outputs fall to zero when nothing is granted.
    always_comb begin
        issue_rob_idx = '0;
        issue_opcode  = '0;
        issue_imm     = '0;
        issue_a       = '0;
        issue_b       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) begin
                issue_rob_idx = issue_rob_idx | issue_src[i].rob_idx;
                issue_opcode  = issue_opcode  | issue_src[i].opcode;
                issue_imm     = issue_imm     | issue_src[i].imm;
                issue_a       = issue_a       | issue_src[i].a_value;
                issue_b       = issue_b       | issue_src[i].b_value;
            end
        end
    end

    // Build the incoming entry, capturing a same-cycle broadcast for pending operands.
    always_comb begin
        alloc         = '0;
        alloc.busy    = 1'b1;
        alloc.rob_idx = in_rob_idx;
        alloc.opcode  = in_opcode;
        alloc.imm     = in_imm;
        alloc.a_valid = in_a_valid;
        alloc.a_value = in_a_value;
        alloc.a_owner = in_a_owner;
        alloc.b_valid = in_b_valid;
        alloc.b_value = in_b_value;
        alloc.b_owner = in_b_owner;
        if (tag_hit(in_a_valid, in_a_owner, cdb_valid, cdb_tag)) begin
            alloc.a_valid = 1'b1;
            alloc.a_value = cdb_value;
        end
        if (tag_hit(in_b_valid, in_b_owner, cdb_valid, cdb_tag)) begin
            alloc.b_valid = 1'b1;
            alloc.b_value = cdb_value;
        end
    end

    // Next queue state: collapse above the issued slot, append at the first
    // free slot after the collapse, and let flush wipe everything.
    always_comb begin
        count_after = count_q - {3'b000, fire};
        removed     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            removed = removed | (fire & grant[i]);
            entries_d[i] = removed ? woke_ext[i+1] : woke_ext[i];
            if (accept && (count_after == 4'(i))) begin
                entries_d[i] = alloc;
            end
        end
        count_d = count_after + {3'b000, accept};
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
            count_d = '0;
        end
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_fxu_reservation_station.sv
// Directed scoreboard bench for fxu_reservation_station. Stimulus pushes the
// expected issued instruction; a negedge monitor pops on every handshake.
module tb_fxu_reservation_station;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  in_rob_idx;
    logic [3:0]  in_opcode;
    logic [7:0]  in_imm;
    logic        in_a_valid;
    logic [15:0] in_a_value;
    logic [3:0]  in_a_owner;
    logic        in_b_valid;
    logic [15:0] in_b_value;
    logic [3:0]  in_b_owner;
    logic        flush;
    logic        full;
    logic [3:0]  count;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [15:0] cdb_value;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_rob_idx;
    logic [3:0]  issue_opcode;
    logic [7:0]  issue_imm;
    logic [15:0] issue_a;
    logic [15:0] issue_b;

    typedef struct packed {
        logic [3:0]  rob;
        logic [3:0]  opc;
        logic [7:0]  imm;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fxu_reservation_station #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_rob_idx    (in_rob_idx),
        .in_opcode     (in_opcode),
        .in_imm        (in_imm),
        .in_a_valid    (in_a_valid),
        .in_a_value    (in_a_value),
        .in_a_owner    (in_a_owner),
        .in_b_valid    (in_b_valid),
        .in_b_value    (in_b_value),
        .in_b_owner    (in_b_owner),
        .flush         (flush),
        .full          (full),
        .count         (count),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .cdb_value     (cdb_value),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_rob_idx (issue_rob_idx),
        .issue_opcode  (issue_opcode),
        .issue_imm     (issue_imm),
        .issue_a       (issue_a),
        .issue_b       (issue_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            exp_t got;
            got = '{issue_rob_idx, issue_opcode, issue_imm, issue_a, issue_b};
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                chk("issue_pkt", 64'(got), 64'(sb.pop_front()));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        in_valid   = 1'b0;
        in_rob_idx = '0;
        in_opcode  = '0;
        in_imm     = '0;
        in_a_valid = 1'b0;
        in_a_value = '0;
        in_a_owner = '0;
        in_b_valid = 1'b0;
        in_b_value = '0;
        in_b_owner = '0;
        cdb_valid  = 1'b0;
        cdb_tag    = '0;
        cdb_value  = '0;
        flush      = 1'b0;
    endtask

    task automatic disp(input logic [3:0] rob, input logic [3:0] opc, input logic [7:0] imm,
                        input logic av, input logic [15:0] aval, input logic [3:0] aown,
                        input logic bv, input logic [15:0] bval, input logic [3:0] bown);
        in_valid   = 1'b1;
        in_rob_idx = rob;
        in_opcode  = opc;
        in_imm     = imm;
        in_a_valid = av;
        in_a_value = aval;
        in_a_owner = aown;
        in_b_valid = bv;
        in_b_value = bval;
        in_b_owner = bown;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        idle_in();
        issue_ready = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_issue_a", 64'(issue_a), 64'd0);
        rst_n = 1'b1;

        // Basic dispatch-to-issue latency.
        issue_ready = 1'b1;
        disp(4'd3, 4'd2, 8'h11, 1'b1, 16'h0005, 4'd0, 1'b1, 16'h0007, 4'd0);
        sb.push_back('{4'd3, 4'd2, 8'h11, 16'h0005, 16'h0007});
        cycle();
        idle_in();
        #1;
        chk("t1_issue_valid_n1", 64'(issue_valid), 64'd1);
        chk("t1_count_1", 64'(count), 64'd1);
        chk("t1_issue_a", 64'(issue_a), 64'h5);
        cycle();
        chk("t1_count_0", 64'(count), 64'd0);
        chk("t1_issue_valid_0", 64'(issue_valid), 64'd0);
        chk("t1_idle_data_zero", 64'({issue_a, issue_b, issue_rob_idx}), 64'd0);

        // Wakeup of a pending operand from the CDB.
        disp(4'd1, 4'd4, 8'h22, 1'b0, 16'h0000, 4'd9, 1'b1, 16'h0002, 4'd0);
        cycle();
        idle_in();
        #1;
        chk("t2_wait_valid", 64'(issue_valid), 64'd0);
        chk("t2_count", 64'(count), 64'd1);
        cycle();
        cdb_valid = 1'b1;
        cdb_tag   = 4'd9;
        cdb_value = 16'h1234;
        sb.push_back('{4'd1, 4'd4, 8'h22, 16'h1234, 16'h0002});
        #1;
`ifdef RS_WAKEUP_FASTPATH_EN
        chk("t2_fast_valid", 64'(issue_valid), 64'd1);
        chk("t2_fast_a", 64'(issue_a), 64'h1234);
        cycle();
        idle_in();
        chk("t2_count_0", 64'(count), 64'd0);
`else
        chk("t2_slow_valid_cdb_cycle", 64'(issue_valid), 64'd0);
        cycle();
        idle_in();
        #1;
        chk("t2_slow_valid", 64'(issue_valid), 64'd1);
        chk("t2_slow_a", 64'(issue_a), 64'h1234);
        cycle();
        chk("t2_count_0", 64'(count), 64'd0);
`endif

        // Capture at allocation from a same-cycle broadcast.
        disp(4'd2, 4'd5, 8'h33, 1'b0, 16'h0000, 4'd5, 1'b1, 16'h0001, 4'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd5;
        cdb_value = 16'hBEEF;
        sb.push_back('{4'd2, 4'd5, 8'h33, 16'hBEEF, 16'h0001});
        cycle();
        idle_in();
        #1;
        chk("t3_valid", 64'(issue_valid), 64'd1);
        chk("t3_a", 64'(issue_a), 64'hBEEF);
        cycle();
        chk("t3_count_0", 64'(count), 64'd0);

        // Fill to full, drop dispatches while full, then drain in order.
        issue_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            disp(4'(4 + k), 4'(k), 8'(8'h40 + k), 1'b1, 16'(16'h0100 + k), 4'd0,
                 1'b1, 16'(16'h0200 + k), 4'd0);
            sb.push_back('{4'(4 + k), 4'(k), 8'(8'h40 + k), 16'(16'h0100 + k), 16'(16'h0200 + k)});
            cycle();
        end
        idle_in();
        #1;
        chk("t4_full", 64'(full), 64'd1);
        chk("t4_count_4", 64'(count), 64'd4);
        disp(4'd8, 4'hF, 8'hFF, 1'b1, 16'hDEAD, 4'd0, 1'b1, 16'hDEAD, 4'd0);
        cycle();
        chk("t4_drop_count", 64'(count), 64'd4);
        issue_ready = 1'b1;
        cycle();
        idle_in();
        issue_ready = 1'b0;
        #1;
        chk("t4_full_after_issue", 64'(full), 64'd0);
        chk("t4_count_3", 64'(count), 64'd3);
        chk("t4_head_kept", 64'(issue_rob_idx), 64'd5);
        issue_ready = 1'b1;
        repeat (3) cycle();
        chk("t4_drained", 64'(count), 64'd0);

        // Oldest-ready selection skips a waiting entry which then collapses to slot 0.
        issue_ready = 1'b0;
        disp(4'd10, 4'd1, 8'h50, 1'b1, 16'h000A, 4'd0, 1'b1, 16'h00A0, 4'd0);
        sb.push_back('{4'd10, 4'd1, 8'h50, 16'h000A, 16'h00A0});
        cycle();
        disp(4'd11, 4'd2, 8'h51, 1'b0, 16'h0000, 4'd12, 1'b1, 16'h00B0, 4'd0);
        cycle();
        disp(4'd13, 4'd3, 8'h52, 1'b1, 16'h000D, 4'd0, 1'b1, 16'h00D0, 4'd0);
        sb.push_back('{4'd13, 4'd3, 8'h52, 16'h000D, 16'h00D0});
        sb.push_back('{4'd11, 4'd2, 8'h51, 16'hCAFE, 16'h00B0});
        cycle();
        idle_in();
        #1;
        chk("t5_count_3", 64'(count), 64'd3);
        chk("t5_head_sel", 64'(issue_rob_idx), 64'd10);
        issue_ready = 1'b1;
        cycle();
        #1;
        chk("t5_second_sel", 64'(issue_rob_idx), 64'd13);
        cycle();
        #1;
        chk("t5_count_1", 64'(count), 64'd1);
        chk("t5_waiting_not_ready", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd12;
        cdb_value = 16'hCAFE;
        cycle();
        idle_in();
        for (int w = 0; w < 4 && count != 4'd0; w++) cycle();
        chk("t5_count_0", 64'(count), 64'd0);

        // Flush overrides a same-cycle dispatch.
        issue_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(4'(1 + k), 4'd7, 8'h60, 1'b1, 16'h1111, 4'd0, 1'b1, 16'h2222, 4'd0);
            cycle();
        end
        disp(4'd4, 4'd7, 8'h61, 1'b1, 16'h3333, 4'd0, 1'b1, 16'h4444, 4'd0);
        flush = 1'b1;
        #1;
        chk("t6_valid_during_flush", 64'(issue_valid), 64'd1);
        cycle();
        idle_in();
        #1;
        chk("t6_count_0", 64'(count), 64'd0);
        chk("t6_valid_0", 64'(issue_valid), 64'd0);
        chk("t6_full_0", 64'(full), 64'd0);

        // Asynchronous reset mid-fill clears outputs without waiting for an edge.
        for (int k = 0; k < 2; k++) begin
            disp(4'(6 + k), 4'd1, 8'h70, 1'b1, 16'h5555, 4'd0, 1'b1, 16'h6666, 4'd0);
            cycle();
        end
        idle_in();
        #1;
        chk("t7_count_2", 64'(count), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_count", 64'(count), 64'd0);
        chk("t7_rst_valid", 64'(issue_valid), 64'd0);
        chk("t7_rst_data", 64'({issue_rob_idx, issue_opcode, issue_imm, issue_a, issue_b}), 64'd0);
        chk("t7_rst_full", 64'(full), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        issue_ready = 1'b1;
        disp(4'd14, 4'd9, 8'h7E, 1'b1, 16'h0ABC, 4'd0, 1'b1, 16'h0DEF, 4'd0);
        sb.push_back('{4'd14, 4'd9, 8'h7E, 16'h0ABC, 16'h0DEF});
        cycle();
        idle_in();
        #1;
        chk("t7_first_after_rst", 64'(issue_valid), 64'd1);
        cycle();
        chk("t7_final_count", 64'(count), 64'd0);

        repeat (2) cycle();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
